// File: rtl/video_pkg.sv
// Shared types, constants and helpers for the video output stage.
package video_pkg;

    localparam int GEOM_W = 32'sd12;

    // Measured frame geometry value.
    typedef logic [GEOM_W-1:0] geom_t;

    // Saturation limit for the pixel and line counters.
    localparam geom_t GEOM_MAX = 12'd4095;

    // Blanking word layout: {8'h00, preset[2:0], 13'h0000}.
    localparam int BLANK_PRESET_LSB = 32'sd13;
    localparam int BLANK_PRESET_MSB = 32'sd15;

    // One pixel as carried through the pipeline.
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } pix_t;

    // Widen a w-bit channel (right-aligned in val) to 8 bits. With rep set,
    // the MSB-aligned copy is ORed with copies shifted right by multiples of
    // w, which fills the LSBs with the input repeated MSB-first.
    function automatic logic [7:0] expand_chan(input logic [7:0] val, input int w, input logic rep);
        logic [7:0] aligned;
        logic [7:0] res;
        aligned = val << (32'sd8 - w);
        res     = aligned;
        if (rep) begin
            for (int k = 1; k < 8; k++) begin
                res = res | (aligned >> (w * k));
            end
        end else begin
            res = aligned;
        end
        return res;
    endfunction

    // Word driven on video_rgb while de is low.
    function automatic logic [23:0] blank_word(input logic [2:0] preset);
        logic [23:0] word;
        word = 24'h000000;
        word[BLANK_PRESET_MSB:BLANK_PRESET_LSB] = preset;
        return word;
    endfunction

endpackage

// File: rtl/video_out_stage_if.sv
// Core-side colour/sync bundle feeding the video output stage.
interface video_out_stage_if #(
    parameter int RW = 32'sd8,
    parameter int GW = 32'sd8,
    parameter int BW = 32'sd8
);
    logic [RW-1:0] core_r;
    logic [GW-1:0] core_g;
    logic [BW-1:0] core_b;
    logic          core_hs;
    logic          core_vs;
    logic          core_de;

    modport master (output core_r, core_g, core_b, core_hs, core_vs, core_de);
    modport slave  (input  core_r, core_g, core_b, core_hs, core_vs, core_de);
endinterface

// File: rtl/video_geom_meter.sv
// Measures active width/height of each frame from stage-1 de and vs and
// publishes them only on a vs rising edge that closes a frame with lines.
module video_geom_meter
    import video_pkg::*;
(
    input  logic  clk_vid,
    input  logic  reset,
    input  logic  de,
    input  logic  vs,
    output geom_t active_width,
    output geom_t active_height,
    output logic  geom_valid
);

    geom_t pix_q, pix_d;
    geom_t width_q, width_d;
    geom_t lines_q, lines_d;
    geom_t aw_q, aw_d;
    geom_t ah_q, ah_d;
    logic  valid_q, valid_d;
    logic  de_hist_q, de_hist_d;
    logic  vs_hist_q, vs_hist_d;
    logic  de_rise_s, de_fall_s, vs_rise_s;

    // Edge detection, counting, and publication of the finished frame.
    always_comb begin
        de_rise_s = de & ~de_hist_q;
        de_fall_s = ~de & de_hist_q;
        vs_rise_s = vs & ~vs_hist_q;
        de_hist_d = de;
        vs_hist_d = vs;
        pix_d     = pix_q;
        width_d   = width_q;
        lines_d   = lines_q;
        aw_d      = aw_q;
        ah_d      = ah_q;
        valid_d   = valid_q;

        // The rising-edge cycle is itself the first pixel of the line.
        if (de_rise_s) begin
            pix_d = 12'd1;
        end else if (de && (pix_q != GEOM_MAX)) begin
            pix_d = pix_q + 12'd1;
        end else begin
            pix_d = pix_q;
        end

        if (de_fall_s) begin
            width_d = pix_q;
            lines_d = (lines_q == GEOM_MAX) ? GEOM_MAX : (lines_q + 12'd1);
        end else begin
            width_d = width_q;
            lines_d = lines_q;
        end

        // lines_d already includes a line ending in this same cycle.
        if (vs_rise_s && (lines_d != 12'd0)) begin
            aw_d    = width_d;
            ah_d    = lines_d;
            valid_d = 1'b1;
            lines_d = 12'd0;
        end else begin
            aw_d    = aw_q;
            ah_d    = ah_q;
            valid_d = valid_q;
        end
    end

    // Counter, history and published-geometry registers.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            pix_q     <= 12'd0;
            width_q   <= 12'd0;
            lines_q   <= 12'd0;
            aw_q      <= 12'd0;
            ah_q      <= 12'd0;
            valid_q   <= 1'b0;
            de_hist_q <= 1'b0;
            vs_hist_q <= 1'b0;
        end else begin
            pix_q     <= pix_d;
            width_q   <= width_d;
            lines_q   <= lines_d;
            aw_q      <= aw_d;
            ah_q      <= ah_d;
            valid_q   <= valid_d;
            de_hist_q <= de_hist_d;
            vs_hist_q <= vs_hist_d;
        end
    end

    assign active_width  = aw_q;
    assign active_height = ah_q;
    assign geom_valid    = valid_q;

endmodule

// File: rtl/video_out_stage.sv
// Video output stage: sync polarity normalisation, colour expansion to
// 8 bits per channel, configurable delay, sync pulse shaping and blanking
// word insertion, plus frame geometry measurement.
module video_out_stage
    import video_pkg::*;
#(
    parameter int RW     = 32'sd8,
    parameter int GW     = 32'sd8,
    parameter int BW     = 32'sd8,
    parameter int EXPAND = 32'sd1,
    parameter int DELAY  = 32'sd0
) (
    input  logic               clk_vid,
    input  logic               reset,
    video_out_stage_if.slave   core,
    input  logic [2:0]         video_preset,
    input  logic               hs_inv,
    input  logic               vs_inv,
    output logic [23:0]        video_rgb,
    output logic               video_hs,
    output logic               video_vs,
    output logic               video_de,
    output geom_t              active_width,
    output geom_t              active_height,
    output logic               geom_valid
);

    localparam logic REP = (EXPAND != 32'sd0);

    // Index 0 is stage 1; index DELAY feeds the output stage.
    pix_t pipe_d [0:DELAY];
    pix_t pipe_q [0:DELAY];
    pix_t stage1_s;
    pix_t tail_s;

    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        hs_hist_q, hs_hist_d;
    logic        vs_hist_q, vs_hist_d;

    // Normalise sync polarity and widen each colour channel to 8 bits.
    always_comb begin
        stage1_s.hs  = core.core_hs ^ hs_inv;
        stage1_s.vs  = core.core_vs ^ vs_inv;
        stage1_s.de  = core.core_de;
        stage1_s.rgb = {expand_chan(8'(core.core_r), RW, REP),
                        expand_chan(8'(core.core_g), GW, REP),
                        expand_chan(8'(core.core_b), BW, REP)};
    end

    // Shift chain: stage 1 followed by DELAY identical stages.
    always_comb begin
        pipe_d[0] = stage1_s;
        for (int i = 1; i <= DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= DELAY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tail_s = pipe_q[DELAY];

    // Output stage: one-cycle sync pulses on rising edges, blanking word when de is low.
    always_comb begin
        hs_hist_d = tail_s.hs;
        vs_hist_d = tail_s.vs;
        hs_d      = tail_s.hs & ~hs_hist_q;
        vs_d      = tail_s.vs & ~vs_hist_q;
        de_d      = tail_s.de;
        if (tail_s.de) begin
            rgb_d = tail_s.rgb;
        end else begin
            rgb_d = blank_word(video_preset);
        end
    end

    // Output registers and sync edge history.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            rgb_q     <= 24'h000000;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            hs_hist_q <= 1'b0;
            vs_hist_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            hs_hist_q <= hs_hist_d;
            vs_hist_q <= vs_hist_d;
        end
    end

    assign video_rgb = rgb_q;
    assign video_hs  = hs_q;
    assign video_vs  = vs_q;
    assign video_de  = de_q;

    video_geom_meter u_geom (
        .clk_vid       (clk_vid),
        .reset         (reset),
        .de            (pipe_q[0].de),
        .vs            (pipe_q[0].vs),
        .active_width  (active_width),
        .active_height (active_height),
        .geom_valid    (geom_valid)
    );

endmodule

// File: tb/tb_video_out_stage.sv
// Scoreboard bench: two instances (replicate with DELAY=2, zero-pad with
// DELAY=0) share one core bundle; stimulus pushes expected outputs, a
// negedge monitor pops and compares them.
module tb_video_out_stage;
    import video_pkg::*;

    localparam int RW = 5;
    localparam int GW = 6;
    localparam int BW = 3;
    localparam int DA = 2;
    localparam int DB = 0;

    typedef struct {
        int          due;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    typedef struct {
        int due;
        int w;
        int h;
    } geo_t;

    logic        clk_vid = 1'b0;
    logic        reset   = 1'b1;
    logic [2:0]  video_preset = 3'd0;
    logic        hs_inv = 1'b0;
    logic        vs_inv = 1'b0;

    logic [23:0] rgb_a, rgb_b;
    logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b;
    geom_t       aw_a, ah_a, aw_b, ah_b;
    logic        gv_a, gv_b;

    video_out_stage_if #(.RW(RW), .GW(GW), .BW(BW)) core_if ();

    video_out_stage #(.RW(RW), .GW(GW), .BW(BW), .EXPAND(1), .DELAY(DA)) dut_a (
        .clk_vid(clk_vid), .reset(reset), .core(core_if.slave),
        .video_preset(video_preset), .hs_inv(hs_inv), .vs_inv(vs_inv),
        .video_rgb(rgb_a), .video_hs(hs_a), .video_vs(vs_a), .video_de(de_a),
        .active_width(aw_a), .active_height(ah_a), .geom_valid(gv_a));

    video_out_stage #(.RW(RW), .GW(GW), .BW(BW), .EXPAND(0), .DELAY(DB)) dut_b (
        .clk_vid(clk_vid), .reset(reset), .core(core_if.slave),
        .video_preset(video_preset), .hs_inv(hs_inv), .vs_inv(vs_inv),
        .video_rgb(rgb_b), .video_hs(hs_b), .video_vs(vs_b), .video_de(de_b),
        .active_width(aw_b), .active_height(ah_b), .geom_valid(gv_b));

    always #5 clk_vid = ~clk_vid;

    int cyc = 0;
    always @(posedge clk_vid) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t qa[$];
    exp_t qb[$];
    geo_t gq[$];
    logic [2:0] preset_hist [int];

    // Reference-model state (logical, polarity-free levels).
    logic m_prev_hs = 1'b0, m_prev_vs = 1'b0, m_prev_de = 1'b0;
    int   m_run = 0, m_lines = 0, m_last_w = 0;
    int   geo_w = 0, geo_h = 0;
    logic geo_v = 1'b0;

    // Channel expansion from the rules: pad zeros, or concatenate copies and keep the top 8 bits.
    function automatic logic [7:0] m_expand(input int v, input int w, input bit rep);
        int acc, bits;
        if (!rep) return 8'(v << (8 - w));
        acc = 0;
        bits = 0;
        while (bits < 8) begin
            acc  = (acc << w) | v;
            bits = bits + w;
        end
        return 8'(acc >> (bits - 8));
    endfunction

    task automatic check_pix(input string nm, input exp_t e, input logic [23:0] rgb,
                             input logic hs, input logic vs, input logic de);
        logic [23:0] er;
        er = e.de ? e.rgb : {8'h00, preset_hist[e.due - 1], 13'h0000};
        n_cmp++;
        if (e.due != cyc || {rgb, hs, vs, de} !== {er, e.hs, e.vs, e.de}) begin
            n_bad++;
            $display("FAIL %s cyc=%0d due=%0d got rgb=%h hs=%b vs=%b de=%b expected rgb=%h hs=%b vs=%b de=%b",
                     nm, cyc, e.due, rgb, hs, vs, de, er, e.hs, e.vs, e.de);
        end
    endtask

    task automatic check_geo(input string nm, input geom_t w, input geom_t h, input logic v,
                             input int ew, input int eh, input logic ev);
        n_cmp++;
        if ({w, h, v} !== {12'(ew), 12'(eh), ev}) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got w=%0d h=%0d valid=%b expected w=%0d h=%0d valid=%b",
                     nm, cyc, w, h, v, ew, eh, ev);
        end
    endtask

    task automatic cmp_val(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: pop expected pixels when due, track published geometry, record preset.
    always @(negedge clk_vid) begin
        exp_t e;
        geo_t g;
        if (reset) begin
            geo_w = 0;
            geo_h = 0;
            geo_v = 1'b0;
        end else begin
            if (qa.size() > 0 && qa[0].due <= cyc) begin
                e = qa.pop_front();
                check_pix("pix_a", e, rgb_a, hs_a, vs_a, de_a);
            end
            if (qb.size() > 0 && qb[0].due <= cyc) begin
                e = qb.pop_front();
                check_pix("pix_b", e, rgb_b, hs_b, vs_b, de_b);
            end
            if (gq.size() > 0 && gq[0].due <= cyc) begin
                g = gq.pop_front();
                geo_w = g.w;
                geo_h = g.h;
                geo_v = 1'b1;
            end
            check_geo("geom_a", aw_a, ah_a, gv_a, geo_w, geo_h, geo_v);
            check_geo("geom_b", aw_b, ah_b, gv_b, geo_w, geo_h, geo_v);
        end
        preset_hist[cyc] = video_preset;
    end

    // Drive one cycle of logical levels and push what each DUT must show.
    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [RW-1:0] r, input logic [GW-1:0] g, input logic [BW-1:0] b);
        exp_t ea, eb;
        geo_t gx;
        core_if.core_de = de;
        core_if.core_hs = hs ^ hs_inv;
        core_if.core_vs = vs ^ vs_inv;
        core_if.core_r  = r;
        core_if.core_g  = g;
        core_if.core_b  = b;
        ea.de  = de;
        ea.hs  = hs & ~m_prev_hs;
        ea.vs  = vs & ~m_prev_vs;
        ea.rgb = {m_expand(int'(r), RW, 1'b1), m_expand(int'(g), GW, 1'b1), m_expand(int'(b), BW, 1'b1)};
        ea.due = cyc + 2 + DA;
        eb     = ea;
        eb.rgb = {m_expand(int'(r), RW, 1'b0), m_expand(int'(g), GW, 1'b0), m_expand(int'(b), BW, 1'b0)};
        eb.due = cyc + 2 + DB;
        qa.push_back(ea);
        qb.push_back(eb);
        // Geometry: a line is a completed run of de; frames close on vs rising.
        if (de) begin
            m_run++;
        end else if (m_prev_de) begin
            m_last_w = (m_run > 4095) ? 4095 : m_run;
            m_lines  = (m_lines >= 4095) ? 4095 : m_lines + 1;
            m_run    = 0;
        end
        if (vs && !m_prev_vs && m_lines > 0) begin
            gx.due = cyc + 2;
            gx.w   = m_last_w;
            gx.h   = m_lines;
            gq.push_back(gx);
            m_lines = 0;
        end
        m_prev_hs = hs;
        m_prev_vs = vs;
        m_prev_de = de;
        @(posedge clk_vid);
        #1;
    endtask

    task automatic drive_rand(input logic de, input logic hs, input logic vs);
        drive(de, hs, vs, RW'($urandom), GW'($urandom), BW'($urandom));
    endtask

    task automatic vs_pulse();
        repeat (3) drive_rand(1'b0, 1'b0, 1'b1);
        repeat (2) drive_rand(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int width, input bit coincident, input bit with_vs);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < width; p++) drive_rand(1'b1, 1'b0, 1'b0);
            if (!(coincident && l == nlines - 1)) begin
                repeat (2) drive_rand(1'b0, 1'b1, 1'b0);
                repeat (2) drive_rand(1'b0, 1'b0, 1'b0);
            end
        end
        if (with_vs) vs_pulse();
    endtask

    task automatic check_geom_now(input int w, input int h, input logic v);
        check_geo("geom_now_a", aw_a, ah_a, gv_a, w, h, v);
        check_geo("geom_now_b", aw_b, ah_b, gv_b, w, h, v);
    endtask

    task automatic apply_reset(input int ncyc);
        reset = 1'b1;
        qa.delete();
        qb.delete();
        gq.delete();
        m_prev_hs = 1'b0;
        m_prev_vs = 1'b0;
        m_prev_de = 1'b0;
        m_run     = 0;
        m_lines   = 0;
        m_last_w  = 0;
        #2;
        cmp_val("reset_out_a", {5'd0, rgb_a, hs_a, vs_a, de_a}, 32'd0);
        cmp_val("reset_out_b", {5'd0, rgb_b, hs_b, vs_b, de_b}, 32'd0);
        cmp_val("reset_geom_a", {7'd0, aw_a, ah_a, gv_a}, 32'd0);
        cmp_val("reset_geom_b", {7'd0, aw_b, ah_b, gv_b}, 32'd0);
        repeat (ncyc) @(posedge clk_vid);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        core_if.core_r  = '0;
        core_if.core_g  = '0;
        core_if.core_b  = '0;
        core_if.core_hs = 1'b0;
        core_if.core_vs = 1'b0;
        core_if.core_de = 1'b0;
        @(posedge clk_vid);
        #1;
        apply_reset(3);

        // Expansion of 5'b10101: replicate -> AD, zero-pad -> A8.
        repeat (4) drive(1'b1, 1'b0, 1'b0, 5'b10101, 6'd0, 3'd0);
        cmp_val("expand_rep_r", {24'd0, rgb_a[23:16]}, 32'h000000AD);
        cmp_val("expand_pad_r", {24'd0, rgb_b[23:16]}, 32'h000000A8);

        // Blanking word carries the preset.
        video_preset = 3'b101;
        repeat (4) drive_rand(1'b0, 1'b0, 1'b0);
        cmp_val("blank_a", {7'd0, rgb_a, de_a}, {7'd0, 24'h00A000, 1'b0});
        cmp_val("blank_b", {7'd0, rgb_b, de_b}, {7'd0, 24'h00A000, 1'b0});

        // Randomised traffic with polarity and preset changes, vs held low.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) video_preset = 3'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                hs_inv = ~hs_inv;
                vs_inv = 1'($urandom);
            end
            drive_rand($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 1'b0);
        end
        repeat (3) drive_rand(1'b0, 1'b0, 1'b0);
        vs_pulse();

        // Active-low hsync held asserted for 40 cycles.
        hs_inv = 1'b1;
        repeat (40) drive_rand(1'b0, 1'b1, 1'b0);
        repeat (6) drive_rand(1'b0, 1'b0, 1'b0);

        send_frame(24, 32, 1'b0, 1'b1);
        check_geom_now(32, 24, 1'b1);
        send_frame(10, 20, 1'b0, 1'b1);
        check_geom_now(20, 10, 1'b1);
        vs_pulse();
        check_geom_now(20, 10, 1'b1);

        // Reset part-way through a frame, then an empty vs must not publish.
        send_frame(10, 20, 1'b0, 1'b0);
        repeat (7) drive_rand(1'b1, 1'b0, 1'b0);
        apply_reset(2);
        vs_pulse();
        check_geom_now(0, 0, 1'b0);
        send_frame(24, 32, 1'b0, 1'b1);
        check_geom_now(32, 24, 1'b1);

        // Saturated width; last de fall coincides with vs rise.
        send_frame(2, 5000, 1'b1, 1'b1);
        check_geom_now(4095, 2, 1'b1);

        for (int i = 0; i < 30 && (qa.size() > 0 || qb.size() > 0 || gq.size() > 0); i++) begin
            @(posedge clk_vid);
        end
        #1;
        n_cmp++;
        if (qa.size() > 0 || qb.size() > 0 || gq.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending a=%0d b=%0d geom=%0d expected 0", qa.size(), qb.size(), gq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_out_stage.md
VIDEO_OUT_STAGE -- requirements
Module: video_out_stage

Interface
REQ-001 Parameter RW, default 8: red input width, legal 1..8.
REQ-002 Parameter GW, default 8: green input width, legal 1..8.
REQ-003 Parameter BW, default 8: blue input width, legal 1..8.
REQ-004 Parameter EXPAND, default 1: 0 = zero-pad LSBs, 1 = replicate MSBs into LSBs.
REQ-005 Parameter DELAY, default 0: extra pipeline stages, legal 0..7.
REQ-006 Clocking SHALL be one clock, clk_vid, with reset asynchronous and active-high, named reset.
REQ-007 clk_vid  in  1  pixel clock; sole clock.
REQ-008 reset  in  1  async active-high reset.
REQ-009 video_preset  in  3  preset code, inserted into blanking word.
REQ-010 hs_inv / vs_inv  in  1 each  1 = core sync is active-low and is inverted.
REQ-011 core_r / core_g / core_b  in  RW / GW / BW  core colour.
REQ-012 core_hs / core_vs / core_de  in  1 each  core sync and data enable.
REQ-013 video_rgb  out  24  R[23:16] G[15:8] B[7:0].
REQ-014 video_hs / video_vs / video_de  out  1 each  display sync pulses and enable.
REQ-015 active_width / active_height  out  12 each  measured geometry of last complete frame.
REQ-016 geom_valid  out  1  high once any frame geometry has been published.

Function
REQ-017 Stage 1 SHALL register polarity-normalised hs/vs (XOR with inv inputs), de, and channels expanded to 8 bits per EXPAND.
REQ-018 Expansion SHALL be per channel: width 8 passes unchanged; replicate mode repeats input MSB-first until 8 bits are filled.
REQ-019 DELAY further register stages SHALL delay rgb, hs, vs and de identically.
REQ-020 The output stage SHALL drive video_de = delayed de; video_rgb = delayed rgb when de, else {8'h00, video_preset, 13'h0000}.
REQ-021 video_hs SHALL be high for exactly one cycle on each rising edge of the delayed normalised hs; video_vs likewise.
REQ-022 Latency core input -> video outputs SHALL be exactly 2 + DELAY clk_vid cycles for all signals.
REQ-023 A pixel counter SHALL count stage-1 de-high cycles, saturating at 4095, and clear on de rising edge.
REQ-024 On de falling edge the line width SHALL be latched and the line counter (saturating at 4095) incremented.
REQ-025 On normalised vs rising edge with line counter nonzero: publish active_width, active_height, set geom_valid, and clear the line counter.
REQ-026 A vs rising edge with line counter zero SHALL leave all published outputs unchanged.
REQ-027 A de falling edge coincident with a vs rising edge SHALL count the ending line before publishing.
REQ-028 Published geometry SHALL change only on a vs rising edge, never mid-frame.

Reset
REQ-029 On reset all pipeline stages, video_rgb, video_hs, video_vs, video_de SHALL be 0.
REQ-030 On reset all counters, active_width, active_height and geom_valid SHALL be 0, and the edge-detect history SHALL be 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first vs edge after release with zero lines counted SHALL not publish.

Structure
REQ-032 A shared package video_pkg SHALL hold the 12-bit geometry typedef, the 4095 saturation constant and the blanking-word field positions.
REQ-033 One sub-module, video_geom_meter (REQ-023..028), SHALL be instantiated; expansion and the pipeline stay inline.

Verification
REQ-034 RW=5, EXPAND=1, core_r=5'b10101, de=1 -> video_rgb[23:16]=8'hAD after 2+DELAY cycles; with EXPAND=0 -> 8'hA8.
REQ-035 de=0, video_preset=3'b101 -> video_rgb=24'h00A000 and video_de=0.
REQ-036 hs_inv=1, core_hs held low for 40 cycles -> video_hs high for exactly 1 cycle, 2+DELAY cycles after the falling edge.
REQ-037 Frame of 240 lines x 320 de cycles, then vs rising -> active_width=320, active_height=240, geom_valid=1; values hold unchanged through the next frame until its vs.
REQ-038 Line with 5000 de cycles -> active_width=4095 (saturated); last de falling coincident with vs rising -> height includes that line.
REQ-039 Reset asserted mid-frame at line 100, released, then vs rising -> outputs stay 0 and geom_valid=0; the next full 240x320 frame publishes correctly.
